// File: rtl/isqrt_pipe_if.sv
// Argument/result bundle for the isqrt_pipe square-root resource.
// master: the caller (drives x_vld/x, receives y_vld/y).
// slave:  the isqrt_pipe block itself.
interface isqrt_pipe_if;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;

  modport master (output x_vld, output x, input y_vld, input y);
  modport slave  (input x_vld, input x, output y_vld, output y);
endinterface

// File: rtl/isqrt_pipe.sv
// Pipelined integer square root: y = floor(sqrt(x)), 32-bit x, 16-bit y.
// Latency: exactly N_STAGES cycles, one result per cycle, no stalls.
// Backpressure: none; every accepted x_vld yields one y_vld pulse in order.
// Ports: clk, rst (synchronous, active-high); io (slave modport):
//   x_vld/x in, y_vld/y out (y forced to 0 while y_vld is low).
module isqrt_pipe #(
  parameter int N_STAGES = 16
) (
  input logic         clk,
  input logic         rst,
  isqrt_pipe_if.slave io
);

  // Root bits resolved in each stage.
  localparam int K = 16 / N_STAGES;

  for (genvar s = 0; s < N_STAGES; s++) begin : stg
    // Stage inputs: either the caller's argument or the previous stage.
    logic        in_vld;
    logic [31:0] in_rad;   // radicand bits not yet consumed, MSB-aligned
    logic [33:0] in_rem;   // running remainder
    logic [15:0] in_root;  // partial root, right-aligned

    // Combinational result of resolving K root bits.
    logic [31:0] rad_n;
    logic [33:0] rem_n;
    logic [15:0] root_n;
    logic [33:0] trial;

    // Stage registers that reach the output side.
    logic        vld_q;
    logic [15:0] root_q;

    if (s == 0) begin : g_src
      assign in_vld  = io.x_vld;
      assign in_rad  = io.x;
      assign in_rem  = '0;
      assign in_root = '0;
    end else begin : g_chain
      assign in_vld  = stg[s-1].vld_q;
      assign in_rad  = stg[s-1].g_carry.rad_q;
      assign in_rem  = stg[s-1].g_carry.rem_q;
      assign in_root = stg[s-1].root_q;
    end

    // Restoring digit-by-digit step: bring down two radicand bits, try to
    // subtract (4*root + 1); a successful subtraction sets the new root bit.
    // The remainder never exceeds 2*root + 1 before the shift, so 34 bits
    // cannot wrap even at x = 32'hFFFFFFFF.
    always_comb begin
      rad_n  = in_rad;
      rem_n  = in_rem;
      root_n = in_root;
      trial  = '0;
      for (int b = 0; b < K; b++) begin
        rem_n = (rem_n << 2) | {32'd0, rad_n[31:30]};
        rad_n = {rad_n[29:0], 2'b00};
        trial = {16'd0, root_n, 2'b01};
        if (rem_n >= trial) begin
          rem_n  = rem_n - trial;
          root_n = {root_n[14:0], 1'b1};
        end else begin
          root_n = {root_n[14:0], 1'b0};
        end
      end
    end

    // Only the valid chain is reset; rst also drops an argument offered in
    // the same cycle, which discards it.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= in_vld;
      end
    end

    // Data loads only behind a valid, so idle stages do not toggle.
    always_ff @(posedge clk) begin
      if (in_vld) begin
        root_q <= root_n;
      end
    end

    // The last stage only needs the finished root.
    if (s < N_STAGES - 1) begin : g_carry
      logic [31:0] rad_q;
      logic [33:0] rem_q;

      always_ff @(posedge clk) begin
        if (in_vld) begin
          rad_q <= rad_n;
          rem_q <= rem_n;
        end
      end
    end
  end

  // Both operands are flops, so there is no path from x to y.
  assign io.y_vld = stg[N_STAGES-1].vld_q;
  assign io.y     = stg[N_STAGES-1].vld_q ? stg[N_STAGES-1].root_q : 16'd0;

endmodule

// File: doc/isqrt_pipe.md
# isqrt_pipe

Pipelined integer square root: computes y = floor(sqrt(x)) for a 32-bit unsigned x and returns a 16-bit result after a fixed latency. It is the shared isqrt resource directly downstream of the formula FSMs, such as formula_2_fsm, which drive its x_vld/x and wait for y_vld/y. It accepts a new argument every cycle with no backpressure. Callers that issue one request at a time and callers that stream back-to-back are both served unchanged.

## Interface
- N_STAGES, default 16: number of pipeline register stages. Legal values are 1, 2, 4, 8 and 16. Root bits resolved per stage = 16 / N_STAGES.
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high; clock clk.
- x_vld  input  1  argument valid; x is sampled on every posedge where x_vld=1
- x  input  32  unsigned radicand
- y_vld  output  1  result valid, one-cycle pulse per accepted argument
- y  output  16  floor(sqrt(x)); forced to 0 while y_vld=0

## Operation
- Digit-by-digit (restoring, non-performing) square root, MSB first.
  - Stage s resolves root bits [15 - s*K, 16 - (s+1)*K], where K = 16 / N_STAGES.
  - For each bit i, form trial = root | (1<<i) and keep the bit iff trial*trial <= x.
  - Equivalent remainder/accumulator form is allowed: 34-bit remainder, 2 radicand bits consumed per root bit.
  - Result must be bit-exact floor(sqrt(x)) for all 2^32 inputs. No rounding.
- Each stage register holds one valid bit, the partial root (16 bits), and either the remaining radicand or the remainder.
- The valid bit travels with the data.
  - The valid chain is reset by rst.
  - Data registers are not reset. They load only when the incoming valid = 1, so idle stages hold their old data with no toggling.
- No stalls, no ready signal. Every accepted argument produces exactly one y_vld pulse, in order of acceptance.
- No internal arithmetic overflow at x = 32'hFFFFFFFF. Widths are sized so that trial^2 and the remainder never wrap: use 33/34-bit intermediates where needed.
- y is gated: y = y_vld ? root_last : 16'd0.

## Timing
- Latency is exactly N_STAGES cycles. If x_vld=1 is sampled at posedge t, then y_vld=1 and y is valid during the cycle after posedge t+N_STAGES-1. With N_STAGES=16, y appears 16 clocks after the request edge.
- The y output is a register output. There is no combinational path from x to y.
- Throughput is 1 result per cycle.
  - N consecutive x_vld cycles produce N consecutive y_vld cycles.
  - Gaps in the input are reproduced unchanged in the output.
- Reset values: y_vld=0 and y=0, from the first clock after rst is sampled high.
- Reset mid-operation:
  - All in-flight requests are discarded and never produce y_vld.
  - x_vld sampled during the rst cycle is ignored.
  - The first request after rst falls is handled normally.
- x_vld=1 in the same cycle that y_vld=1: both happen independently. The pipeline has no occupancy limit.
- Single-request callers (formula FSM): holding x_vld for 1 cycle yields exactly one y_vld. The FSM never sees a spurious second pulse.

## Test plan
- Corner values, N_STAGES=16, one request each, ~20-cycle gaps:
  - x=0 -> y=0
  - x=1 -> y=1
  - x=15 -> y=3
  - x=16 -> y=4
  - x=32'hFFFFFFFF -> y=16'hFFFF
  - x=32'hFFFE0001 -> y=16'hFFFF
  - x=32'hFFFE0000 -> y=16'hFFFE
  - y_vld rises exactly 16 clocks after each request edge.
- Back-to-back stream: 1000 consecutive random x with x_vld held high -> 1000 consecutive y_vld cycles, each y equal to the reference-model floor(sqrt(x)), in order.
- Sparse traffic: x_vld pattern 1,0,0,1,1,0,1 with x=100,_,_,99,81,_,2 -> y_vld pattern identical after a 16-cycle shift, with y=10,9,9,1.
- Reset mid-flight: issue 5 requests, assert rst for 1 cycle at request 3 + 4 cycles -> no y_vld at any point afterward; then x=144 -> y=12 after 16 cycles. y_vld=0 and y=0 throughout reset.
- Parameter sweep: repeat the random stream test with N_STAGES = 1, 2, 4 and 8 -> latencies of 1, 2, 4 and 8 cycles respectively, all results bit-exact.
- System check: connect to formula_2_fsm with a=0, b=0, c=256 -> isqrt chain 16, 4, 2 -> res=2, with res_vld high for exactly one cycle.
